// File: rtl/wb_pkg.sv
// Shared types and default widths for the Wishbone classic initiator.
package wb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      RESP
   } wb_init_state_e;

   localparam int unsigned WB_ADR_W = 32;
   localparam int unsigned WB_DAT_W = 32;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Cycle counter for the bus-phase watchdog. Instantiated by wb_initiator only
// when WB_INITIATOR_TIMEOUT_EN is defined.
module wb_timeout_ctr #(
   parameter  int unsigned TIMEOUT_CYCLES = 256,
   localparam int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator: one request -> one cyc/stb/ack -> one response.
// Optional bus watchdog enabled by defining WB_INITIATOR_TIMEOUT_EN.
module wb_initiator
   import wb_pkg::*;
#(
   parameter  int unsigned ADR_W          = WB_ADR_W,
   parameter  int unsigned DAT_W          = WB_DAT_W,
   parameter  int unsigned TIMEOUT_CYCLES = 256,
   localparam int unsigned SEL_W          = DAT_W / 8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_we_i,
   input  logic [ADR_W-1:0] req_adr_i,
   input  logic [DAT_W-1:0] req_dat_i,
   input  logic [SEL_W-1:0] req_sel_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [DAT_W-1:0] rsp_dat_o,
   output logic             rsp_err_o,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [ADR_W-1:0] wbm_adr_o,
   output logic [DAT_W-1:0] wbm_dat_o,
   output logic [SEL_W-1:0] wbm_sel_o,
   input  logic             wbm_ack_i,
   input  logic [DAT_W-1:0] wbm_dat_i
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("wb_initiator: TIMEOUT_CYCLES must be >= 2");
   end

   wb_init_state_e state_q, state_d;
   logic           abort;

`ifdef WB_INITIATOR_TIMEOUT_EN
   logic expired;

   // Counter is held clear outside BUS, so it restarts at zero on every entry.
   wb_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clk    (wb_clk_i),
      .rst_n  (wb_rst_n_i),
      .clear  (state_q != BUS),
      .enable ((state_q == BUS) && !wbm_ack_i),
      .expired(expired)
   );

   assign abort = expired && !wbm_ack_i;
`else
   assign abort = 1'b0;
`endif

   assign req_ready_o = (state_q == IDLE);
   assign wbm_stb_o   = wbm_cyc_o;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid_i) state_d = BUS;
         BUS:     if (wbm_ack_i || abort) state_d = RESP;
         RESP:    if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         wbm_cyc_o   <= 1'b0;
         wbm_we_o    <= 1'b0;
         wbm_adr_o   <= '0;
         wbm_dat_o   <= '0;
         wbm_sel_o   <= '0;
         rsp_valid_o <= 1'b0;
         rsp_dat_o   <= '0;
         rsp_err_o   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  wbm_cyc_o <= 1'b1;
                  wbm_we_o  <= req_we_i;
                  wbm_adr_o <= req_adr_i;
                  wbm_dat_o <= req_dat_i;
                  wbm_sel_o <= req_sel_i;
               end
            end
            BUS: begin
               // An ack in the expiry cycle wins over the abort.
               if (wbm_ack_i || abort) begin
                  wbm_cyc_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= !wbm_ack_i;
                  rsp_dat_o   <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : '0;
               end
            end
            RESP: begin
               if (rsp_ready_i) rsp_valid_o <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator; timeout cases run when WB_INITIATOR_TIMEOUT_EN is defined.
module tb_wb_initiator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_adr = '0;
   logic [31:0] req_dat = '0;
   logic [3:0]  req_sel = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        cyc, stb, we;
   logic [31:0] adr, dat_o;
   logic [3:0]  sel;
   logic        ack = 1'b0;
   logic [31:0] dat_i = '0;

   int checks = 0;
   int failures = 0;

   wb_initiator #(
      .ADR_W(32),
      .DAT_W(32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .req_valid_i(req_valid),
      .req_ready_o(req_ready),
      .req_we_i   (req_we),
      .req_adr_i  (req_adr),
      .req_dat_i  (req_dat),
      .req_sel_i  (req_sel),
      .rsp_valid_o(rsp_valid),
      .rsp_ready_i(rsp_ready),
      .rsp_dat_o  (rsp_dat),
      .rsp_err_o  (rsp_err),
      .wbm_cyc_o  (cyc),
      .wbm_stb_o  (stb),
      .wbm_we_o   (we),
      .wbm_adr_o  (adr),
      .wbm_dat_o  (dat_o),
      .wbm_sel_o  (sel),
      .wbm_ack_i  (ack),
      .wbm_dat_i  (dat_i)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      req_valid = 1'b1;
      req_we    = w;
      req_adr   = a;
      req_dat   = d;
      req_sel   = s;
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_cyc", 32'(cyc), 32'd0);
      check("rst_stb", 32'(stb), 32'd0);
      check("rst_adr", adr, 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_dat", rsp_dat, 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      step();
      #3 rst_n = 1'b1;
      step();

      // Zero-wait read
      rsp_ready = 1'b1;
      issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
      step();
      req_valid = 1'b0;
      check("rd_cyc", 32'(cyc), 32'd1);
      check("rd_stb", 32'(stb), 32'd1);
      check("rd_we", 32'(we), 32'd0);
      check("rd_adr", adr, 32'h3000_0010);
      check("rd_req_ready", 32'(req_ready), 32'd0);
      check("rd_no_rsp_yet", 32'(rsp_valid), 32'd0);
      ack = 1'b1;
      dat_i = 32'hA5A5_1234;
      step();
      ack = 1'b0;
      check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
      check("rd_rsp_dat", rsp_dat, 32'hA5A5_1234);
      check("rd_rsp_err", 32'(rsp_err), 32'd0);
      check("rd_cyc_drop", 32'(cyc), 32'd0);
      step();
      check("rd_rsp_done", 32'(rsp_valid), 32'd0);
      check("rd_idle", 32'(req_ready), 32'd1);

      // Write with 5 wait states, then response backpressure
      rsp_ready = 1'b0;
      issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'b0011);
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("wr_cyc", 32'(cyc), 32'd1);
         check("wr_stb", 32'(stb), 32'd1);
         check("wr_we", 32'(we), 32'd1);
         check("wr_adr", adr, 32'h3000_0004);
         check("wr_dat", dat_o, 32'hDEAD_BEEF);
         check("wr_sel", 32'(sel), 32'h3);
         check("wr_rsp_wait", 32'(rsp_valid), 32'd0);
         ack = (i == 5);
         dat_i = 32'h7777_7777;
         step();
      end
      ack = 1'b0;
      check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
      check("wr_rsp_dat", rsp_dat, 32'd0);
      check("wr_cyc_drop", 32'(cyc), 32'd0);
      check("wr_adr_retained", adr, 32'h3000_0004);
      // Pending request and spurious acks while the response is stalled
      issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
      for (int i = 0; i < 4; i++) begin
         ack = (i == 1 || i == 2);
         dat_i = 32'hFFFF_FFFF;
         step();
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rsp_dat", rsp_dat, 32'd0);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         check("bp_cyc", 32'(cyc), 32'd0);
      end
      ack = 1'b0;
      rsp_ready = 1'b1;
      step();
      check("bp_rsp_done", 32'(rsp_valid), 32'd0);
      check("bp_idle", 32'(req_ready), 32'd1);
      check("bp_not_yet", 32'(cyc), 32'd0);
      step();
      req_valid = 1'b0;
      check("bp_next_cyc", 32'(cyc), 32'd1);
      check("bp_next_adr", adr, 32'h3000_0020);
      check("bp_next_we", 32'(we), 32'd0);
      ack = 1'b1;
      dat_i = 32'h1111_2222;
      step();
      ack = 1'b0;
      check("bp_next_rsp", rsp_dat, 32'h1111_2222);
      step();

      // Spurious ack in IDLE
      ack = 1'b1;
      step();
      step();
      ack = 1'b0;
      check("idle_ack_cyc", 32'(cyc), 32'd0);
      check("idle_ack_rsp", 32'(rsp_valid), 32'd0);
      check("idle_ack_ready", 32'(req_ready), 32'd1);

`ifdef WB_INITIATOR_TIMEOUT_EN
      // No ack: abort after 8 BUS cycles
      issue(1'b0, 32'h3000_0100, 32'h0, 4'hF);
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("to_cyc_high", 32'(cyc), 32'd1);
         step();
      end
      check("to_cyc_drop", 32'(cyc), 32'd0);
      check("to_rsp_valid", 32'(rsp_valid), 32'd1);
      check("to_rsp_err", 32'(rsp_err), 32'd1);
      check("to_rsp_dat", rsp_dat, 32'd0);
      step();
      // Ack exactly in the expiry cycle
      issue(1'b0, 32'h3000_0104, 32'h0, 4'hF);
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 7; i++) step();
      check("to_edge_cyc", 32'(cyc), 32'd1);
      ack = 1'b1;
      dat_i = 32'h0BAD_F00D;
      step();
      ack = 1'b0;
      check("to_edge_valid", 32'(rsp_valid), 32'd1);
      check("to_edge_err", 32'(rsp_err), 32'd0);
      check("to_edge_dat", rsp_dat, 32'h0BAD_F00D);
      step();
`else
      // Without the watchdog the bus waits for ack indefinitely
      issue(1'b0, 32'h3000_0100, 32'h0, 4'hF);
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 20; i++) step();
      check("nt_cyc_held", 32'(cyc), 32'd1);
      check("nt_no_rsp", 32'(rsp_valid), 32'd0);
      ack = 1'b1;
      dat_i = 32'h0BAD_F00D;
      step();
      ack = 1'b0;
      check("nt_rsp_dat", rsp_dat, 32'h0BAD_F00D);
      check("nt_rsp_err", 32'(rsp_err), 32'd0);
      step();
`endif

      // Reset in the middle of BUS
      issue(1'b1, 32'h3000_0200, 32'h1234_5678, 4'hF);
      step();
      req_valid = 1'b0;
      check("mr_cyc_pre", 32'(cyc), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mr_cyc_async", 32'(cyc), 32'd0);
      check("mr_stb_async", 32'(stb), 32'd0);
      check("mr_adr_cleared", adr, 32'd0);
      #2 rst_n = 1'b1;
      step();
      check("mr_ready", 32'(req_ready), 32'd1);
      check("mr_no_rsp", 32'(rsp_valid), 32'd0);
      issue(1'b1, 32'h3000_0008, 32'hCAFE_F00D, 4'b1100);
      step();
      req_valid = 1'b0;
      check("mr_next_adr", adr, 32'h3000_0008);
      check("mr_next_sel", 32'(sel), 32'hC);
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("mr_next_rsp", 32'(rsp_valid), 32'd1);
      check("mr_next_dat", rsp_dat, 32'd0);
      step();
      check("mr_next_idle", 32'(req_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
